// File: rtl/ram_bist_ctrl.sv
// Two-pass march-style BIST controller for a single-port synchronous RAM.
// Each pass writes a seeded address pattern across the whole array, then
// reads it back and compares one cycle later. The second pass uses the
// inverted pattern. Every output is registered.
module ram_bist_ctrl #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] data_in,
    output logic              write_enable,
    input  logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [6:0]        err_count,
    output logic [ADDR_W-1:0] fail_addr
);

    localparam int unsigned ERR_W = 7;
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Pattern for address a in pass p: zero-extended address XOR seed, inverted in pass 1.
    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a,
                                              input logic              p,
                                              input logic [DATA_W-1:0] s);
        logic [DATA_W-1:0] v;
        v = DATA_W'(a) ^ s;
        return p ? ~v : v;
    endfunction

    logic [2:0]        state_q, state_d;
    logic              p_q, p_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic              cmp_valid_q, cmp_valid_d;
    logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] din_d;
    logic              we_d;
    logic              busy_d;
    logic              done_d;
    logic              pass_d;
    logic [ERR_W-1:0]  err_d;
    logic [ADDR_W-1:0] fail_d;
    logic              mismatch_c;

    // Read data arrives one cycle after its address, so compare against the delayed address.
    assign mismatch_c = cmp_valid_q && (data_out != pat(cmp_addr_q, p_q, seed_q));

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            p_q          <= 1'b0;
            seed_q       <= '0;
            cmp_valid_q  <= 1'b0;
            cmp_addr_q   <= '0;
            ram_address  <= '0;
            data_in      <= '0;
            write_enable <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_count    <= '0;
            fail_addr    <= '0;
        end else begin
            state_q      <= state_d;
            p_q          <= p_d;
            seed_q       <= seed_d;
            cmp_valid_q  <= cmp_valid_d;
            cmp_addr_q   <= cmp_addr_d;
            ram_address  <= addr_d;
            data_in      <= din_d;
            write_enable <= we_d;
            busy         <= busy_d;
            done         <= done_d;
            pass         <= pass_d;
            err_count    <= err_d;
            fail_addr    <= fail_d;
        end
    end

    // Next-state, address sequencing, compare bookkeeping and next output values.
    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        seed_d      = seed_q;
        cmp_valid_d = 1'b0;
        cmp_addr_d  = cmp_addr_q;
        addr_d      = '0;
        din_d       = '0;
        we_d        = 1'b0;
        pass_d      = pass;
        err_d       = err_count;
        fail_d      = fail_addr;

        if (mismatch_c) begin
            if (err_count == '0) begin
                fail_d = cmp_addr_q;
            end
            if (err_count != ERR_MAX) begin
                err_d = err_count + ERR_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WRITE;
                    seed_d  = seed;
                    p_d     = 1'b0;
                    we_d    = 1'b1;
                    din_d   = pat('0, 1'b0, seed);
                    err_d   = '0;
                    fail_d  = '0;
                    pass_d  = 1'b0;
                end
            end
            S_WRITE: begin
                if (ram_address == ADDR_LAST) begin
                    state_d = S_READ;
                end else begin
                    addr_d = ram_address + ADDR_W'(1);
                    we_d   = 1'b1;
                    din_d  = pat(ram_address + ADDR_W'(1), p_q, seed_q);
                end
            end
            S_READ: begin
                cmp_valid_d = 1'b1;
                cmp_addr_d  = ram_address;
                if (ram_address == ADDR_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    addr_d = ram_address + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                if (!p_q) begin
                    p_d     = 1'b1;
                    state_d = S_WRITE;
                    we_d    = 1'b1;
                    din_d   = pat('0, 1'b1, seed_q);
                end else begin
                    state_d = S_DONE;
                    pass_d  = (err_d == '0);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_WRITE) || (state_d == S_READ) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: behavioural RAM with fault injection, a per-test
// expectation model and a scoreboard monitor sampling on the falling edge.
module tb_ram_bist_ctrl;

    typedef struct packed {
        logic [5:0] a;
        logic [7:0] d;
    } wr_t;

    typedef struct packed {
        logic [6:0] err;
        logic [5:0] fa;
        logic       ps;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] seed = '0;
    logic [5:0] ram_address;
    logic [7:0] data_in;
    logic       write_enable;
    logic [7:0] data_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [6:0] err_count;
    logic [5:0] fail_addr;

    bit clk_run = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;

    // fault injection controls for the RAM model
    int         fmode = 0;
    logic [5:0] ffa   = '0;
    logic [7:0] fmask = 8'h01;

    logic [7:0] mem [64];
    wr_t        wq[$];
    res_t       dq[$];
    res_t       last_res = '0;
    logic [7:0] w7q[$];
    int         done_seen = 0;
    bit         active = 1'b0;
    int         cnt = 0;

    ram_bist_ctrl #(.ADDR_W(6), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
        .ram_address(ram_address), .data_in(data_in), .write_enable(write_enable),
        .data_out(data_out), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_addr(fail_addr)
    );

    initial begin
        wait (clk_run);
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rd_fault(input logic [7:0] stored, input logic [5:0] a);
        case (fmode)
            1:       return (a == ffa) ? (stored & 8'hFE) : stored;
            2:       return 8'hFF;
            3:       return (a == ffa) ? (stored ^ fmask) : stored;
            default: return stored;
        endcase
    endfunction

    // Behavioural single-port synchronous RAM with read-path fault injection.
    always @(posedge clk) begin
        if (write_enable) mem[ram_address] <= data_in;
        data_out <= rd_fault(mem[ram_address], ram_address);
    end

    // Reference model: on acceptance, derive the full write stream and final result.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active = 1'b0;
            cnt = 0;
            wq.delete();
            dq.delete();
        end else if (active) begin
            cnt++;
            if (cnt == 259) active = 1'b0;
        end else if (start) begin
            int   mis;
            res_t r;
            active = 1'b1;
            cnt = 0;
            mis = 0;
            r = '0;
            for (int p = 0; p < 2; p++) begin
                for (int a = 0; a < 64; a++) begin
                    logic [7:0] e;
                    e = 8'(a) ^ seed;
                    if (p == 1) e = ~e;
                    wq.push_back('{a: 6'(a), d: e});
                end
                for (int a = 0; a < 64; a++) begin
                    logic [7:0] e;
                    e = 8'(a) ^ seed;
                    if (p == 1) e = ~e;
                    if (rd_fault(e, 6'(a)) != e) begin
                        if (mis == 0) r.fa = 6'(a);
                        mis++;
                    end
                end
            end
            r.err = (mis > 127) ? 7'd127 : 7'(mis);
            r.ps  = (mis == 0);
            dq.push_back(r);
        end
    end

    // Scoreboard monitor, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", busy, active && cnt < 258);
            chk("done_timing", done, active && cnt == 258);
            if (write_enable) begin
                if (ram_address == 6'd7) w7q.push_back(data_in);
                if (wq.size() == 0) begin
                    chk("write_unexpected", 1, 0);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("wr_addr", ram_address, w.a);
                    chk("wr_data", data_in, w.d);
                end
            end
            if (done) begin
                done_seen++;
                if (dq.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    last_res = dq.pop_front();
                    chk("err_count", err_count, last_res.err);
                    chk("fail_addr", fail_addr, last_res.fa);
                    chk("pass", pass, last_res.ps);
                    chk("writes_left", wq.size(), 0);
                end
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 400 && active; i++) @(negedge clk);
        chk("idle_timeout", active, 0);
    endtask

    task automatic hold_check();
        repeat (3) @(negedge clk);
        chk("hold_pass", pass, last_res.ps);
        chk("hold_err", err_count, last_res.err);
        chk("hold_fail", fail_addr, last_res.fa);
    endtask

    task automatic run_test(input logic [7:0] s, input int m, input logic [5:0] a, input logic [7:0] mk);
        @(negedge clk);
        seed  = s;
        fmode = m;
        ffa   = a;
        fmask = mk;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seed  = 8'($urandom);
        wait_idle();
        hold_check();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        for (int i = 0; i < 64; i++) mem[i] = '0;

        // reset with the clock stopped
        #3;
        chk("rst_addr", ram_address, 0);
        chk("rst_din", data_in, 0);
        chk("rst_we", write_enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_count, 0);
        chk("rst_fail", fail_addr, 0);

        clk_run = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // seed 0x10, healthy RAM, address-7 write data in both passes
        run_test(8'h10, 0, '0, 8'h01);
        chk("w7_count", w7q.size(), 2);
        if (w7q.size() >= 2) begin
            chk("w7_pass0", w7q[0], 8'h17);
            chk("w7_pass1", w7q[1], 8'hE8);
        end
        chk("t1_pass", pass, 1);

        // stuck-at-0 on bit0 at address 7
        run_test(8'h10, 1, 6'd7, 8'h01);
        chk("t2_err", err_count, 1);
        chk("t2_fail", fail_addr, 7);

        // RAM always returns 0xFF, saturation
        run_test(8'h00, 2, '0, 8'h01);
        chk("t3_err", err_count, 127);
        chk("t3_fail", fail_addr, 0);

        // randomized tests
        for (int t = 0; t < 6; t++) begin
            run_test(8'($urandom), int'($urandom_range(0, 3)), 6'($urandom), 8'($urandom_range(1, 255)));
        end

        // start held high: two completions within 600 cycles, none accepted while busy
        @(negedge clk);
        seed  = 8'($urandom);
        fmode = 0;
        d0 = done_seen;
        start = 1'b1;
        repeat (600) @(negedge clk);
        start = 1'b0;
        chk("held_done_cnt", done_seen - d0, 2);
        wait_idle();
        hold_check();

        // asynchronous reset while writing address 20
        @(negedge clk);
        seed  = 8'h5A;
        fmode = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100 && !(write_enable && ram_address == 6'd20); i++) @(negedge clk);
        chk("reach_addr20", write_enable && ram_address == 6'd20, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_addr", ram_address, 0);
        chk("mid_rst_din", data_in, 0);
        chk("mid_rst_we", write_enable, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_err", err_count, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_test(8'hC3, 0, '0, 8'h01);
        chk("post_rst_pass", pass, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
